// File: rtl/normshift_iter_pkg.sv
// normshift_iter_pkg
//   Shared definitions for the iterative normalization shifter: the FSM state type,
//   the default sizing of the post-processor instance, and helpers that derive the
//   cycle count and step-counter width from the shift-amount width and radix.
package normshift_iter_pkg;

    typedef enum logic [1:0] {
        NS_IDLE,
        NS_SHIFT,
        NS_DONE
    } normshift_state_t;

    localparam int unsigned NS_SZ    = 64;
    localparam int unsigned NS_LOGSZ = $clog2(NS_SZ);
    localparam int unsigned NS_RB    = 2;

    // Worst-case number of SHIFT cycles: one per RB-bit chunk of the amount.
    localparam int unsigned NSCYCLES = (NS_LOGSZ + NS_RB - 1) / NS_RB;

    function automatic int unsigned nsCycles(input int unsigned logSz, input int unsigned rb);
        return (logSz + rb - 1) / rb;
    endfunction

    // K counts chunks retired; one spare bit so it can reach the cycle count itself.
    function automatic int unsigned nsKWidth(input int unsigned logSz, input int unsigned rb);
        return $clog2(nsCycles(logSz, rb)) + 1;
    endfunction

endpackage

// File: rtl/normshift_iter_if.sv
// normshift_iter_if
//   Operation handshake bundle for normshift_iter.
//   Input side : InValid/InReady with ShiftIn, ShiftAmt, SideIn.
//   Output side: OutValid/OutReady with Shifted, SideOut.
//   master - producer of operations / consumer of results (upstream + downstream logic)
//   slave  - the shifter itself
interface normshift_iter_if #(
    parameter int unsigned SZ    = 64,
    parameter int unsigned LOGSZ = $clog2(SZ),
    parameter int unsigned SBW   = 16
);

    logic             InValid;
    logic             InReady;
    logic [SZ-1:0]    ShiftIn;
    logic [LOGSZ-1:0] ShiftAmt;
    logic [SBW-1:0]   SideIn;
    logic             OutValid;
    logic             OutReady;
    logic [SZ-1:0]    Shifted;
    logic [SBW-1:0]   SideOut;

    modport master (
        output InValid, ShiftIn, ShiftAmt, SideIn, OutReady,
        input  InReady, OutValid, Shifted, SideOut
    );

    modport slave (
        input  InValid, ShiftIn, ShiftAmt, SideIn, OutReady,
        output InReady, OutValid, Shifted, SideOut
    );

endinterface

// File: rtl/normshift_iter_step.sv
// normshift_step
//   Combinational single-step shifter: shOut = shIn << (chunk << (RB*k)).
//   Ports:
//     shIn  [SZ]  current partial result
//     chunk [RB]  shift-amount chunk retired this cycle
//     k     [KW]  chunk index (weight 2^(RB*k))
//     shOut [SZ]  shifted value; steps reaching SZ or beyond yield zero
module normshift_step #(
    parameter int unsigned SZ = 64,
    parameter int unsigned RB = 2,
    parameter int unsigned KW = 3
) (
    input  logic [SZ-1:0] shIn,
    input  logic [RB-1:0] chunk,
    input  logic [KW-1:0] k,
    output logic [SZ-1:0] shOut
);

    // Wide enough that an over-range step still compares >= SZ instead of wrapping.
    localparam int unsigned AW = 32;

    logic [AW-1:0] stepAmt;

    always_comb begin
        stepAmt = AW'(chunk) << (RB * AW'(k));
        shOut   = shIn << stepAmt;
    end

endmodule

// File: rtl/normshift_iter.sv
// normshift_iter
//   Multi-cycle normalization shifter ahead of shiftcorrection. Left-shifts the
//   significand by ShiftAmt, retiring RB amount bits per cycle, and stops as soon as
//   the remaining upper chunks are all zero. A sideband rides along unmodified.
//   Ports:
//     clk, reset   clock; asynchronous active-high reset
//     Flush        synchronous kill of any in-flight operation, highest priority
//     bus (slave)  InValid/InReady/ShiftIn/ShiftAmt/SideIn in,
//                  OutValid/OutReady/Shifted/SideOut out
//     Busy         high whenever the FSM is not idle
module normshift_iter
    import normshift_iter_pkg::*;
#(
    parameter int unsigned SZ    = 64,
    parameter int unsigned LOGSZ = $clog2(SZ),
    parameter int unsigned RB    = 2,
    parameter int unsigned SBW   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Flush,
    normshift_iter_if.slave  bus,
    output logic             Busy
);

    localparam int unsigned KW = nsKWidth(LOGSZ, RB);

    normshift_state_t state;
    logic [SZ-1:0]    sh;
    logic [SZ-1:0]    shStep;
    logic [LOGSZ-1:0] rem;
    logic [LOGSZ-1:0] remNext;
    logic [KW-1:0]    k;
    logic [SBW-1:0]   side;
    logic             accept;

    normshift_step #(
        .SZ (SZ),
        .RB (RB),
        .KW (KW)
    ) uStep (
        .shIn  (sh),
        .chunk (rem[RB-1:0]),
        .k     (k),
        .shOut (shStep)
    );

    assign remNext = rem >> RB;

    // DONE with OutReady accepts directly, so back-to-back operations see no bubble.
    assign bus.InReady  = ~Flush & ((state == NS_IDLE) | ((state == NS_DONE) & bus.OutReady));
    assign accept       = bus.InValid & bus.InReady;
    assign bus.OutValid = (state == NS_DONE);
    assign bus.Shifted  = sh;
    assign bus.SideOut  = side;
    assign Busy         = (state != NS_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= NS_IDLE;
            sh    <= '0;
            rem   <= '0;
            k     <= '0;
            side  <= '0;
        end else if (Flush) begin
            // Data registers are left as-is; only the control state is killed.
            state <= NS_IDLE;
        end else begin
            unique case (state)
                NS_IDLE, NS_DONE: begin
                    if (accept) begin
                        sh    <= bus.ShiftIn;
                        rem   <= bus.ShiftAmt;
                        k     <= '0;
                        side  <= bus.SideIn;
                        state <= (bus.ShiftAmt == '0) ? NS_DONE : NS_SHIFT;
                    end else if ((state == NS_DONE) && bus.OutReady) begin
                        state <= NS_IDLE;
                    end
                end
                NS_SHIFT: begin
                    sh  <= shStep;
                    rem <= remNext;
                    k   <= k + KW'(1);
                    // Stop as soon as no nonzero chunk remains above this one.
                    if (remNext == '0) begin
                        state <= NS_DONE;
                    end
                end
                default: begin
                    state <= NS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_normshift_iter.sv
// tb_normshift_iter
//   Self-checking bench for normshift_iter (SZ=64, RB=2, SBW=16). Directed scenarios
//   followed by a randomized run scored against a behavioural model: result is
//   ShiftIn << ShiftAmt, done after 1 + (number of RB-bit chunks up to the highest
//   nonzero one) cycles.
module tb_normshift_iter;

    localparam int unsigned SZ    = 64;
    localparam int unsigned LOGSZ = 6;
    localparam int unsigned RB    = 2;
    localparam int unsigned SBW   = 16;
    localparam int unsigned NSC   = 3;
    localparam int unsigned NOPS  = 6000;

    logic clk = 1'b0;
    logic reset;
    logic Flush;
    logic Busy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    normshift_iter_if #(.SZ(SZ), .LOGSZ(LOGSZ), .SBW(SBW)) bus ();

    normshift_iter #(
        .SZ    (SZ),
        .LOGSZ (LOGSZ),
        .RB    (RB),
        .SBW   (SBW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Flush (Flush),
        .bus   (bus),
        .Busy  (Busy)
    );

    // Number of shift cycles: count of RB-bit chunks up to the highest nonzero one.
    function automatic int refCycles(input int amt);
        int n;
        n = 0;
        for (int i = 0; i < int'(NSC); i++) begin
            if ((amt >> (RB * i)) != 0) n = i + 1;
        end
        return n;
    endfunction

    task automatic idleInputs;
        bus.InValid  = 1'b0;
        bus.ShiftIn  = '0;
        bus.ShiftAmt = '0;
        bus.SideIn   = '0;
        bus.OutReady = 1'b1;
        Flush        = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idleInputs();
        @(negedge clk);
        #1;
        checks++;
        if (bus.OutValid !== 1'b0) $display("FAIL reset_outvalid got %b want 0", bus.OutValid);
        else passed++;
        checks++;
        if (bus.InReady !== 1'b1) $display("FAIL reset_inready got %b want 1", bus.InReady);
        else passed++;
        checks++;
        if (Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", Busy);
        else passed++;
        checks++;
        if (bus.Shifted !== 64'h0 || bus.SideOut !== 16'h0)
            $display("FAIL reset_data got %h/%h want 0/0", bus.Shifted, bus.SideOut);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_shift;
        @(negedge clk);
        bus.ShiftIn  = 64'h1;
        bus.ShiftAmt = LOGSZ'(63);
        bus.SideIn   = 16'hbeef;
        bus.InValid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.InValid = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b1) $display("FAIL midrst_busy_before got %b want 1", Busy);
        else passed++;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1 || Busy !== 1'b0)
            $display("FAIL midrst_ctrl got ov=%b ir=%b busy=%b want 0/1/0",
                     bus.OutValid, bus.InReady, Busy);
        else passed++;
        checks++;
        if (bus.Shifted !== 64'h0) $display("FAIL midrst_shifted got %h want 0", bus.Shifted);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_latency(input string name, input logic [63:0] din, input int amt,
                                input logic [63:0] expRes);
        logic [15:0] side;
        int lat;
        int expLat;
        side   = 16'($urandom);
        expLat = 1 + refCycles(amt);
        @(negedge clk);
        bus.ShiftIn  = din;
        bus.ShiftAmt = LOGSZ'(amt);
        bus.SideIn   = side;
        bus.InValid  = 1'b1;
        bus.OutReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.InValid = 1'b0;
        #1;
        lat = 1;
        if (expLat > 1) begin
            checks++;
            if (bus.InReady !== 1'b0 || Busy !== 1'b1)
                $display("FAIL %s_busy got ir=%b busy=%b want 0/1", name, bus.InReady, Busy);
            else passed++;
        end
        while (bus.OutValid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== expLat) $display("FAIL %s_latency got %0d want %0d", name, lat, expLat);
        else passed++;
        checks++;
        if (bus.Shifted !== expRes) $display("FAIL %s_shifted got %h want %h", name, bus.Shifted, expRes);
        else passed++;
        checks++;
        if (bus.SideOut !== side) $display("FAIL %s_side got %h want %h", name, bus.SideOut, side);
        else passed++;
        @(negedge clk);
        #1;
        checks++;
        if (bus.OutValid !== 1'b0 || Busy !== 1'b0 || bus.InReady !== 1'b1)
            $display("FAIL %s_idle got ov=%b busy=%b ir=%b want 0/0/1",
                     name, bus.OutValid, Busy, bus.InReady);
        else passed++;
    endtask

    task automatic test_stall_back_to_back;
        logic [63:0] dinA;
        logic [63:0] dinB;
        logic [15:0] sideA;
        logic [15:0] sideB;
        int w;
        dinA  = {$urandom, $urandom};
        dinB  = {$urandom, $urandom};
        sideA = 16'($urandom);
        sideB = 16'($urandom);
        @(negedge clk);
        bus.ShiftIn  = dinA;
        bus.ShiftAmt = LOGSZ'(7);
        bus.SideIn   = sideA;
        bus.InValid  = 1'b1;
        bus.OutReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Offer op B throughout the stall; it must not be taken.
        bus.ShiftIn  = dinB;
        bus.ShiftAmt = '0;
        bus.SideIn   = sideB;
        #1;
        w = 0;
        while (bus.OutValid !== 1'b1 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.OutValid !== 1'b1 || bus.Shifted !== (dinA << 7) || bus.SideOut !== sideA)
                $display("FAIL stall_hold[%0d] got ov=%b %h/%h want 1 %h/%h", i, bus.OutValid,
                         bus.Shifted, bus.SideOut, dinA << 7, sideA);
            else passed++;
            checks++;
            if (bus.InReady !== 1'b0) $display("FAIL stall_inready[%0d] got %b want 0", i, bus.InReady);
            else passed++;
            @(negedge clk);
            #1;
        end
        bus.OutReady = 1'b1;
        #1;
        checks++;
        if (bus.InReady !== 1'b1) $display("FAIL b2b_inready got %b want 1", bus.InReady);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        bus.InValid = 1'b0;
        #1;
        checks++;
        if (bus.OutValid !== 1'b1 || bus.Shifted !== dinB || bus.SideOut !== sideB)
            $display("FAIL b2b_result got ov=%b %h/%h want 1 %h/%h",
                     bus.OutValid, bus.Shifted, bus.SideOut, dinB, sideB);
        else passed++;
        @(negedge clk);
        #1;
        checks++;
        if (Busy !== 1'b0) $display("FAIL b2b_idle got %b want 0", Busy);
        else passed++;
    endtask

    task automatic test_flush;
        int seen;
        @(negedge clk);
        bus.ShiftIn  = {$urandom, $urandom};
        bus.ShiftAmt = LOGSZ'(63);
        bus.SideIn   = 16'($urandom);
        bus.InValid  = 1'b1;
        bus.OutReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ShiftAmt = '0;
        Flush        = 1'b1;
        #1;
        checks++;
        if (bus.InReady !== 1'b0) $display("FAIL flush_inready got %b want 0", bus.InReady);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        Flush       = 1'b0;
        bus.InValid = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0) $display("FAIL flush_idle got busy=%b want 0", Busy);
        else passed++;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.OutValid !== 1'b0) seen++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (seen != 0) $display("FAIL flush_outvalid got %0d valid cycles want 0", seen);
        else passed++;
    endtask

    task automatic test_random;
        bit          inflight;
        bit          done;
        int          cnt;
        logic [63:0] mRes;
        logic [15:0] mSide;
        bit          expReady;
        int          ops;
        int          cyc;
        int          amt;
        logic [63:0] din;
        inflight = 0;
        done     = 0;
        cnt      = 0;
        mRes     = '0;
        mSide    = '0;
        ops      = 0;
        cyc      = 0;
        while (ops < int'(NOPS) && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            din = {$urandom, $urandom};
            amt = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 63));
            bus.ShiftIn  = din;
            bus.ShiftAmt = LOGSZ'(amt);
            bus.SideIn   = 16'($urandom);
            bus.InValid  = ($urandom_range(0, 9) < 6);
            bus.OutReady = ($urandom_range(0, 9) < 7);
            Flush        = ($urandom_range(0, 49) == 0);
            #1;
            expReady = !Flush && (!inflight || (done && bus.OutReady));
            checks++;
            if (bus.OutValid !== done || Busy !== inflight || bus.InReady !== expReady)
                $display("FAIL rand_ctrl cyc %0d got ov=%b busy=%b ir=%b want %b/%b/%b", cyc,
                         bus.OutValid, Busy, bus.InReady, done, inflight, expReady);
            else passed++;
            if (done) begin
                checks++;
                if (bus.Shifted !== mRes || bus.SideOut !== mSide)
                    $display("FAIL rand_data cyc %0d got %h/%h want %h/%h", cyc,
                             bus.Shifted, bus.SideOut, mRes, mSide);
                else passed++;
            end
            if (Flush) begin
                inflight = 0;
                done     = 0;
            end else if (bus.InValid && expReady) begin
                inflight = 1;
                cnt      = refCycles(amt);
                done     = (cnt == 0);
                mRes     = din << amt;
                mSide    = bus.SideIn;
                ops++;
            end else if (inflight && !done) begin
                cnt--;
                done = (cnt == 0);
            end else if (done && bus.OutReady) begin
                inflight = 0;
                done     = 0;
            end
        end
        checks++;
        if (ops < int'(NOPS)) $display("FAIL rand_budget got %0d ops want %0d", ops, NOPS);
        else passed++;
        idleInputs();
    endtask

    initial begin
        logic [63:0] d32;
        test_reset();
        test_latency("amt0", 64'h1, 0, 64'h1);
        test_latency("amt5", 64'h1, 5, 64'h20);
        test_latency("amt63", 64'h1, 63, 64'h8000_0000_0000_0000);
        d32 = {$urandom, $urandom};
        test_latency("amt32", d32, 32, d32 << 32);
        test_stall_back_to_back();
        test_flush();
        test_reset_mid_shift();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
